// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
// Shares one SRAM controller port between the data-cache path (D, read/write)
// and the instruction-refill path (I, read-only). Round-robin on ties, one
// outstanding transaction, and a watchdog that aborts a transaction the
// controller never completes. Every output comes straight from a flop.
module sram_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int WDATA_W = 32,
   parameter int RDATA_W = 64,
   parameter int TIMEOUT = 256,
   parameter int CNT_W   = 9
) (
   input  logic               clk,
   input  logic               rst,
   // requester D
   input  logic               d_read,
   input  logic               d_write,
   input  logic [ADDR_W-1:0]  d_addr,
   input  logic [WDATA_W-1:0] d_wdata,
   output logic               d_ack,
   output logic [RDATA_W-1:0] d_rdata,
   // requester I
   input  logic               i_read,
   input  logic [ADDR_W-1:0]  i_addr,
   output logic               i_ack,
   output logic [RDATA_W-1:0] i_rdata,
   // SRAM controller
   output logic               mem_read,
   output logic               mem_write,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [WDATA_W-1:0] mem_wdata,
   input  logic [RDATA_W-1:0] mem_rdata,
   input  logic               mem_ready,
   // status
   output logic               busy,
   output logic               owner,
   output logic               timeout_err
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   localparam bit               WDOG_EN  = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic [0:0]         state_q,       state_d;
   logic               owner_q,       owner_d;
   logic               mem_read_q,    mem_read_d;
   logic               mem_write_q,   mem_write_d;
   logic [ADDR_W-1:0]  mem_addr_q,    mem_addr_d;
   logic [WDATA_W-1:0] mem_wdata_q,   mem_wdata_d;
   logic               d_ack_q,       d_ack_d;
   logic               i_ack_q,       i_ack_d;
   logic [RDATA_W-1:0] d_rdata_q,     d_rdata_d;
   logic [RDATA_W-1:0] i_rdata_q,     i_rdata_d;
   logic               timeout_err_q, timeout_err_d;
   logic [CNT_W-1:0]   cnt_q,         cnt_d;

   logic d_elig;
   logic i_elig;
   logic grant_i;

   // Next-state logic: arbitration in IDLE, completion/abort in BUSY.
   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
      state_d       = state_q;
      owner_d       = owner_q;
      mem_read_d    = mem_read_q;
      mem_write_d   = mem_write_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      d_rdata_d     = d_rdata_q;
      i_rdata_d     = i_rdata_q;
      cnt_d         = cnt_q;
      d_ack_d       = 1'b0;
      i_ack_d       = 1'b0;
      timeout_err_d = 1'b0;

      // A request still held during its own ack cycle must not be re-granted.
      d_elig  = (d_read | d_write) & ~d_ack_q;
      i_elig  = i_read & ~i_ack_q;
      // I wins if it is the only one eligible, or on a tie when D went last.
      grant_i = i_elig & (~d_elig | ~owner_q);

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (d_elig | i_elig) begin
               state_d = ST_BUSY;
               owner_d = grant_i;
               if (grant_i) begin
                  mem_read_d  = 1'b1;
                  mem_write_d = 1'b0;
                  mem_addr_d  = i_addr;
                  mem_wdata_d = '0;
               end else begin
                  // Read and write together from D is treated as a write.
                  mem_read_d  = ~d_write;
                  mem_write_d = d_write;
                  mem_addr_d  = d_addr;
                  mem_wdata_d = d_wdata;
               end
            end
         end
         ST_BUSY: begin
            if (mem_ready) begin
               state_d     = ST_IDLE;
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               cnt_d       = '0;
               if (owner_q) begin
                  i_ack_d = 1'b1;
                  if (!mem_write_q) i_rdata_d = mem_rdata;
               end else begin
                  d_ack_d = 1'b1;
                  if (!mem_write_q) d_rdata_d = mem_rdata;
               end
            end else if (WDOG_EN && (cnt_q == CNT_LAST)) begin
               // Controller never answered: ack with error, read data untouched.
               state_d       = ST_IDLE;
               mem_read_d    = 1'b0;
               mem_write_d   = 1'b0;
               cnt_d         = '0;
               timeout_err_d = 1'b1;
               if (owner_q) i_ack_d = 1'b1;
               else         d_ack_d = 1'b1;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers; reset drops any in-flight transaction silently.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         owner_q       <= 1'b0;
         mem_read_q    <= 1'b0;
         mem_write_q   <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         d_ack_q       <= 1'b0;
         i_ack_q       <= 1'b0;
         d_rdata_q     <= '0;
         i_rdata_q     <= '0;
         timeout_err_q <= 1'b0;
         cnt_q         <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
         state_q       <= state_d;
         owner_q       <= owner_d;
         mem_read_q    <= mem_read_d;
         mem_write_q   <= mem_write_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         d_ack_q       <= d_ack_d;
         i_ack_q       <= i_ack_d;
         d_rdata_q     <= d_rdata_d;
         i_rdata_q     <= i_rdata_d;
         timeout_err_q <= timeout_err_d;
         cnt_q         <= cnt_d;
      end
   end

   assign busy        = (state_q == ST_BUSY);
   assign owner       = owner_q;
   assign mem_read    = mem_read_q;
   assign mem_write   = mem_write_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign d_ack       = d_ack_q;
   assign i_ack       = i_ack_q;
   assign d_rdata     = d_rdata_q;
   assign i_rdata     = i_rdata_q;
   assign timeout_err = timeout_err_q;

endmodule
